bound_flash_monitor: RTL and testbench

- Receiving end of the bound_flash lamp bus: samples the 16-lamp output and decodes it back into level, direction and segment events.
- Checks that the bus follows the legal thermometer protocol. A legal step changes the lit count by at most one lamp per sample.
- Counts completed full cycles: reach all-on, then return to all-off.
- Sits beside bound_flash in the top level, for self-check and status display.

---
 rtl/bound_flash_pkg.sv | 20 ++
 rtl/bound_flash_monitor_if.sv | 20 ++
 rtl/bound_flash_monitor_therm_decode.sv | 29 ++
 rtl/bound_flash_monitor.sv | 192 +++++++++++++++++++
 tb/tb_bound_flash_monitor.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/bound_flash_pkg.sv
// Shared encodings for the bound_flash lamp bus and its monitor.
// Phase and error-code values are visible on status ports.
package bound_flash_pkg;

  localparam int N_LAMP_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    ERR  = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    NOT_THERM = 2'd1,
    JUMP      = 2'd2
  } err_code_e;

endpackage

// File: rtl/bound_flash_monitor_if.sv
// Lamp bus as seen between bound_flash and its monitor.
// The producer drives a sample plus a qualifying valid.
interface bound_flash_monitor_if #(
  parameter int N_LAMP = 16
);

  logic [N_LAMP-1:0] lamp;
  logic              lamp_valid;

  modport master (
    output lamp,
    output lamp_valid
  );

  modport slave (
    input lamp,
    input lamp_valid
  );

endinterface

// File: rtl/bound_flash_monitor_therm_decode.sv
// Combinational thermometer decoder: legal iff lamp == 2^n-1.
// n is the lit-lamp count, valid only when legal is set.
module therm_decode #(
  parameter int N_LAMP = 16,
  parameter int LVL_W  = $clog2(N_LAMP + 1)
) (
  input  logic [N_LAMP-1:0] lamp,
  output logic              legal,
  output logic [LVL_W-1:0]  n
);

  logic [N_LAMP:0] ext;
  logic [N_LAMP:0] inc;

  // 2^n-1 plus one has no bit in common with itself
  always_comb begin
    ext   = {1'b0, lamp};
    inc   = ext + (N_LAMP + 1)'(1);
    legal = ((ext & inc) == '0);
  end

  always_comb begin
    n = '0;
    for (int i = 0; i < N_LAMP; i++) begin
      n = n + LVL_W'(lamp[i]);
    end
  end

endmodule

// File: rtl/bound_flash_monitor.sv
// Receiving-end checker for the bound_flash lamp bus: tracks level,
// reversals and full cycles, and flags thermometer protocol errors.
module bound_flash_monitor
  import bound_flash_pkg::*;
#(
  parameter int N_LAMP = N_LAMP_DEF,
  parameter int CNT_W  = 8,
  parameter int LVL_W  = $clog2(N_LAMP + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  bound_flash_monitor_if.slave  bus,
  output logic [1:0]            phase,
  output logic [LVL_W-1:0]      level,
  output logic [LVL_W-1:0]      last_peak,
  output logic [LVL_W-1:0]      last_trough,
  output logic                  turn,
  output logic                  cycle_done,
  output logic [CNT_W-1:0]      cycle_count,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam logic [LVL_W:0] NMAX = (LVL_W + 1)'(N_LAMP);

  phase_e          phase_q, phase_d;
  err_code_e       code_q, code_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] peak_q, peak_d;
  logic [LVL_W-1:0] trough_q, trough_d;
  logic [LVL_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            turn_q, turn_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic             legal;
  logic [LVL_W-1:0] n;

  therm_decode #(
    .N_LAMP (N_LAMP),
    .LVL_W  (LVL_W)
  ) u_dec (
    .lamp  (bus.lamp),
    .legal (legal),
    .n     (n)
  );

  logic [LVL_W:0] nx;
  logic [LVL_W:0] px;
  logic           up;
  logic           dn;
  logic           same;

  // Widened compares keep p-1 / p+1 free of wraparound
  always_comb begin
    nx   = {1'b0, n};
    px   = {1'b0, level_q};
    up   = (nx == px + 1'b1) && (px != NMAX);
    dn   = (nx + 1'b1 == px);
    same = (nx == px);
  end

  always_comb begin
    phase_d  = phase_q;
    code_d   = code_q;
    level_d  = level_q;
    peak_d   = peak_q;
    trough_d = trough_q;
    max_d    = max_q;
    cnt_d    = cnt_q;
    turn_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (bus.lamp_valid) begin
      if (!legal) begin
        err_d   = 1'b1;
        code_d  = NOT_THERM;
        phase_d = ERR;
        max_d   = '0;
      end else begin
        unique case (phase_q)
          IDLE: begin
            if (n == '0) begin
              phase_d = IDLE;
            end else if (nx == 1) begin
              phase_d = RISE;
              level_d = n;
              max_d   = n;
            end else begin
              err_d   = 1'b1;
              code_d  = JUMP;
              phase_d = ERR;
              max_d   = '0;
            end
          end
          RISE: begin
            if (up) begin
              level_d = n;
              if (n > max_q) max_d = n;
            end else if (same) begin
              phase_d = RISE;
            end else if (dn) begin
              phase_d = FALL;
              peak_d  = level_q;
              turn_d  = 1'b1;
              level_d = n;
            end else begin
              err_d   = 1'b1;
              code_d  = JUMP;
              phase_d = ERR;
              max_d   = '0;
            end
          end
          FALL: begin
            if (dn) begin
              level_d = n;
              if (n == '0) begin
                phase_d = IDLE;
                max_d   = '0;
                if ({1'b0, max_q} == NMAX) begin
                  done_d = 1'b1;
                  if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
              end
            end else if (same) begin
              phase_d = FALL;
            end else if (up) begin
              phase_d  = RISE;
              trough_d = level_q;
              turn_d   = 1'b1;
              level_d  = n;
              if (n > max_q) max_d = n;
            end else begin
              err_d   = 1'b1;
              code_d  = JUMP;
              phase_d = ERR;
              max_d   = '0;
            end
          end
          ERR: begin
            // Only an all-off sample recovers; other legal samples are ignored
            if (n == '0) begin
              phase_d = IDLE;
              level_d = '0;
              max_d   = '0;
            end
          end
          default: phase_d = ERR;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= IDLE;
      code_q   <= NONE;
      level_q  <= '0;
      peak_q   <= '0;
      trough_q <= '0;
      max_q    <= '0;
      cnt_q    <= '0;
      turn_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      code_q   <= code_d;
      level_q  <= level_d;
      peak_q   <= peak_d;
      trough_q <= trough_d;
      max_q    <= max_d;
      cnt_q    <= cnt_d;
      turn_q   <= turn_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign phase       = phase_q;
  assign level       = level_q;
  assign last_peak   = peak_q;
  assign last_trough = trough_q;
  assign turn        = turn_q;
  assign cycle_done  = done_q;
  assign cycle_count = cnt_q;
  assign err         = err_q;
  assign err_code    = code_q;

endmodule

// File: tb/tb_bound_flash_monitor.sv
// Directed table-driven bench for bound_flash_monitor.
// Each vector applies one sample and checks all registered outputs.
module tb_bound_flash_monitor;
  import bound_flash_pkg::*;

  typedef struct packed {
    logic [1:0] ph;
    logic [4:0] lv;
    logic [4:0] pk;
    logic [4:0] tr;
    logic       tu;
    logic       dn;
    logic [7:0] cnt;
    logic       er;
    logic [1:0] cd;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic [15:0] lamp;
    out_t        exp;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] phase;
  logic [4:0] level;
  logic [4:0] last_peak;
  logic [4:0] last_trough;
  logic       turn;
  logic       cycle_done;
  logic [7:0] cycle_count;
  logic       err;
  logic [1:0] err_code;

  int pass_cnt;
  int total_cnt;
  int vec_idx;

  vec_t tbl[$];

  bound_flash_monitor_if #(.N_LAMP(16)) bus ();

  bound_flash_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .phase       (phase),
    .level       (level),
    .last_peak   (last_peak),
    .last_trough (last_trough),
    .turn        (turn),
    .cycle_done  (cycle_done),
    .cycle_count (cycle_count),
    .err         (err),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] therm(input int k);
    logic [31:0] t;
    t = (32'd1 << k) - 32'd1;
    return t[15:0];
  endfunction

  function automatic vec_t v(
    input logic r, input logic val, input logic [15:0] l,
    input logic [1:0] ph, input int lv, input int pk, input int tr,
    input logic tu, input logic dn, input int cnt,
    input logic er, input logic [1:0] cd);
    vec_t t;
    t.rst       = r;
    t.valid     = val;
    t.lamp      = l;
    t.exp.ph    = ph;
    t.exp.lv    = 5'(lv);
    t.exp.pk    = 5'(pk);
    t.exp.tr    = 5'(tr);
    t.exp.tu    = tu;
    t.exp.dn    = dn;
    t.exp.cnt   = 8'(cnt);
    t.exp.er    = er;
    t.exp.cd    = cd;
    return t;
  endfunction

  task automatic run(input vec_t t);
    out_t got;
    @(negedge clk);
    rst            = t.rst;
    bus.lamp       = t.lamp;
    bus.lamp_valid = t.valid;
    @(posedge clk);
    #1;
    got = {phase, level, last_peak, last_trough, turn,
           cycle_done, cycle_count, err, err_code};
    total_cnt++;
    if (got === t.exp) pass_cnt++;
    else $display("FAIL vec%0d lamp=%h got=%h required=%h",
                  vec_idx, t.lamp, got, t.exp);
    vec_idx++;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) run(tbl[i]);
    tbl.delete();
  endtask

  // One full 0 -> all-on -> 0 ramp starting from IDLE
  task automatic do_ramp(input int pk0, input int tr0, input int c0);
    int c1;
    c1 = (c0 == 255) ? 255 : c0 + 1;
    for (int k = 1; k <= 16; k++)
      run(v(0, 1, therm(k), RISE, k, pk0, tr0, 0, 0, c0, 0, NONE));
    for (int k = 15; k >= 0; k--)
      run(v(0, 1, therm(k), (k == 0) ? IDLE : FALL, k, 16, tr0,
            k == 15, k == 0, (k == 0) ? c1 : c0, 0, NONE));
  endtask

  initial begin
    pass_cnt       = 0;
    total_cnt      = 0;
    vec_idx        = 0;
    rst            = 1'b1;
    bus.lamp       = '0;
    bus.lamp_valid = 1'b0;

    // Partial ramp to 6 and back: no cycle completion
    tbl.push_back(v(1, 0, 16'h0000, IDLE, 0, 0, 0, 0, 0, 0, 0, NONE));
    tbl.push_back(v(0, 1, 16'h0000, IDLE, 0, 0, 0, 0, 0, 0, 0, NONE));
    for (int k = 1; k <= 6; k++)
      tbl.push_back(v(0, 1, therm(k), RISE, k, 0, 0, 0, 0, 0, 0, NONE));
    for (int k = 5; k >= 0; k--)
      tbl.push_back(v(0, 1, therm(k), (k == 0) ? IDLE : FALL, k, 6, 0,
                      k == 5, 0, 0, 0, NONE));
    run_tbl();

    // Full ramp: one cycle_done on the all-off sample
    do_ramp(6, 0, 0);
    run(v(0, 1, 16'h0000, IDLE, 0, 16, 0, 0, 0, 1, 0, NONE));

    // Kickback reversal
    tbl.push_back(v(1, 0, 16'h0000, IDLE, 0, 0, 0, 0, 0, 0, 0, NONE));
    for (int k = 1; k <= 6; k++)
      tbl.push_back(v(0, 1, therm(k), RISE, k, 0, 0, 0, 0, 0, 0, NONE));
    tbl.push_back(v(0, 1, 16'h001F, FALL, 5, 6, 0, 1, 0, 0, 0, NONE));
    tbl.push_back(v(0, 1, 16'h001F, FALL, 5, 6, 0, 0, 0, 0, 0, NONE));
    tbl.push_back(v(0, 1, 16'h000F, FALL, 4, 6, 0, 0, 0, 0, 0, NONE));
    tbl.push_back(v(0, 1, 16'h001F, RISE, 5, 6, 4, 1, 0, 0, 0, NONE));
    // Jump error, ERR hold, recovery
    tbl.push_back(v(1, 0, 16'h0000, IDLE, 0, 0, 0, 0, 0, 0, 0, NONE));
    tbl.push_back(v(0, 1, 16'h0001, RISE, 1, 0, 0, 0, 0, 0, 0, NONE));
    tbl.push_back(v(0, 1, 16'h0007, ERR, 1, 0, 0, 0, 0, 0, 1, JUMP));
    tbl.push_back(v(0, 1, 16'h0003, ERR, 1, 0, 0, 0, 0, 0, 0, JUMP));
    tbl.push_back(v(0, 1, 16'h0000, IDLE, 0, 0, 0, 0, 0, 0, 0, JUMP));
    // Non-thermometer sample, then idle bus with garbage
    tbl.push_back(v(0, 1, 16'h0005, ERR, 0, 0, 0, 0, 0, 0, 1, NOT_THERM));
    for (int i = 0; i < 10; i++)
      tbl.push_back(v(0, 0, 16'hA5A5, ERR, 0, 0, 0, 0, 0, 0, 0, NOT_THERM));
    tbl.push_back(v(0, 1, 16'h00A0, ERR, 0, 0, 0, 0, 0, 0, 1, NOT_THERM));
    tbl.push_back(v(0, 1, 16'h0003, ERR, 0, 0, 0, 0, 0, 0, 0, NOT_THERM));
    tbl.push_back(v(0, 1, 16'h0000, IDLE, 0, 0, 0, 0, 0, 0, 0, NOT_THERM));
    tbl.push_back(v(0, 1, 16'h0003, ERR, 0, 0, 0, 0, 0, 0, 1, JUMP));
    tbl.push_back(v(0, 1, 16'h0000, IDLE, 0, 0, 0, 0, 0, 0, 0, JUMP));
    // Plateau at all-on, then illegal jump down from the top
    tbl.push_back(v(1, 0, 16'h0000, IDLE, 0, 0, 0, 0, 0, 0, 0, NONE));
    for (int k = 1; k <= 16; k++)
      tbl.push_back(v(0, 1, therm(k), RISE, k, 0, 0, 0, 0, 0, 0, NONE));
    tbl.push_back(v(0, 1, 16'hFFFF, RISE, 16, 0, 0, 0, 0, 0, 0, NONE));
    tbl.push_back(v(0, 1, 16'h3FFF, ERR, 16, 0, 0, 0, 0, 0, 1, JUMP));
    run_tbl();

    // Reset mid-rise at level 9 with three completed cycles
    run(v(1, 0, 16'h0000, IDLE, 0, 0, 0, 0, 0, 0, 0, NONE));
    do_ramp(0, 0, 0);
    do_ramp(16, 0, 1);
    do_ramp(16, 0, 2);
    for (int k = 1; k <= 9; k++)
      run(v(0, 1, therm(k), RISE, k, 16, 0, 0, 0, 3, 0, NONE));
    run(v(1, 1, therm(10), IDLE, 0, 0, 0, 0, 0, 0, 0, NONE));
    run(v(0, 1, 16'h0001, RISE, 1, 0, 0, 0, 0, 0, 0, NONE));

    // Counter saturation at all-ones
    run(v(1, 0, 16'h0000, IDLE, 0, 0, 0, 0, 0, 0, 0, NONE));
    for (int c = 0; c < 257; c++)
      do_ramp((c == 0) ? 0 : 16, 0, (c > 255) ? 255 : c);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
